// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the iterative multiplier
//   MULT_WIDTH : default operand width
//   MULT_CNT_W : iteration counter width at the default operand width
//   cnt_width  : counter width for an arbitrary operand width
//   mult_state_e : IDLE / BUSY sequencer states
package mult_pkg;

  localparam int MULT_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_e;

endpackage

// File: rtl/mult_unit_if.sv
// rtl/mult_unit_if.sv - execute-stage request/result bundle for mult_unit
//   master : pipeline side, drives start_multE, mult_signE, SrcAE, SrcBE, abort;
//            observes mult_busy, mult_done, HI, LO
//   slave  : multiplier side, the reverse directions
interface mult_unit_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) ();

  logic             start_multE;
  logic             mult_signE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             abort;
  logic             mult_busy;
  logic             mult_done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start_multE, mult_signE, SrcAE, SrcBE, abort,
    input  mult_busy, mult_done, HI, LO
  );

  modport slave (
    input  start_multE, mult_signE, SrcAE, SrcBE, abort,
    output mult_busy, mult_done, HI, LO
  );

endinterface

// File: rtl/mult_sign_adj.sv
// rtl/mult_sign_adj.sv - conditional two's-complement (abs on entry, negate on exit)
//   Present only when MULT_SIGNED_EN is defined.
//   val_i : W-bit input value
//   neg_i : 1 = output the two's-complement negation of val_i
//   val_o : W-bit adjusted value
`ifdef MULT_SIGNED_EN
module mult_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule
`endif

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - iterative radix-2 shift-add multiplier producing HI/LO
//   Optional signed support: MULT_SIGNED_EN (defined = MULT/MULTU, undefined = MULTU only)
//   CLK   : pipeline clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mult_unit_if.slave
//           start_multE, mult_signE, SrcAE, SrcBE, abort in
//           mult_busy (stall request), mult_done (1-cycle pulse), HI, LO out
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic        CLK,
  input  logic        reset,
  mult_unit_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             neg_q;
  logic             done_q;

  // Operand capture values (magnitudes when signed)
  logic [WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]   mplier_d;
  logic               neg_d;

  // One shift-add step and the final product
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]   mq_step;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_d;

`ifdef MULT_SIGNED_EN
  logic neg_a;
  logic neg_b;

  assign neg_a = bus.mult_signE & bus.SrcAE[WIDTH-1];
  assign neg_b = bus.mult_signE & bus.SrcBE[WIDTH-1];
  assign neg_d = neg_a ^ neg_b;

  // The most negative operand maps onto its own bit pattern, which is
  // exactly its magnitude read as unsigned, so it needs no special case.
  mult_sign_adj #(.W(WIDTH)) u_abs_a (
    .val_i (bus.SrcAE),
    .neg_i (neg_a),
    .val_o (mcand_d)
  );

  mult_sign_adj #(.W(WIDTH)) u_abs_b (
    .val_i (bus.SrcBE),
    .neg_i (neg_b),
    .val_o (mplier_d)
  );

  mult_sign_adj #(.W(2*WIDTH)) u_neg_p (
    .val_i (prod_raw),
    .neg_i (neg_q),
    .val_o (prod_d)
  );
`else
  logic unused_sign;

  assign neg_d       = 1'b0;
  assign mcand_d     = bus.SrcAE;
  assign mplier_d    = bus.SrcBE;
  assign prod_d      = prod_raw;
  assign unused_sign = bus.mult_signE ^ neg_q;
`endif

  // Keep the adder carry so it can shift into the accumulator MSB
  always_comb begin
    sum_w = {1'b0, acc_q};
    if (mq_q[0]) begin
      sum_w = {1'b0, acc_q} + {1'b0, mcand_q};
    end
  end

  assign acc_step = sum_w[WIDTH:1];
  assign mq_step  = {sum_w[0], mq_q[WIDTH-1:1]};
  assign prod_raw = {acc_step, mq_step};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort beats a simultaneous start
          if (bus.start_multE && !bus.abort) begin
            mcand_q <= mcand_d;
            mq_q    <= mplier_d;
            neg_q   <= neg_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // A start arriving here is dropped; the hazard unit holds it off.
          if (bus.abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_step;
            mq_q  <= mq_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              hi_q    <= prod_d[2*WIDTH-1:WIDTH];
              lo_q    <= prod_d[WIDTH-1:0];
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.mult_busy = (state_q == BUSY);
  assign bus.mult_done = done_q;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - scoreboard testbench for mult_unit (honours MULT_SIGNED_EN)
module tb_mult_unit;

  logic CLK;
  logic reset;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
`ifdef MULT_SIGNED_EN
    if (s) return 64'(sa * sb);
`endif
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every mult_done pulse is matched against the oldest expectation
  always @(negedge CLK) begin
    logic [63:0] e;
    if (reset === 1'b1 && bus.mult_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("hi", {32'd0, bus.HI}, {32'd0, e[63:32]});
        check("lo", {32'd0, bus.LO}, {32'd0, e[31:0]});
      end
    end
  end

  // Issue one request; returns #1 after the capture edge E0
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s);
    @(posedge CLK);
    #1;
    bus.start_multE = 1'b1;
    bus.mult_signE  = s;
    bus.SrcAE       = a;
    bus.SrcBE       = b;
    @(posedge CLK);
    #1;
    bus.start_multE = 1'b0;
    bus.SrcAE       = 32'($urandom);
    bus.SrcBE       = 32'($urandom);
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit s, input bit interfere);
    int lat;
    int busy_cyc;
    exp_q.push_back(ref_prod(a, b, s));
    start_op(a, b, s);
    lat = 0;
    busy_cyc = 0;
    while (bus.mult_done !== 1'b1 && lat < 40) begin
      if (bus.mult_busy === 1'b1) busy_cyc++;
      if (interfere && lat == 5) begin
        bus.start_multE = 1'b1;
        bus.mult_signE  = ~s;
        bus.SrcAE       = a ^ 32'h0F0F_1234;
        bus.SrcBE       = b + 32'd9;
      end
      if (interfere && lat == 6) bus.start_multE = 1'b0;
      @(posedge CLK);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd32);
    check("busy_cycles", 64'(busy_cyc), 64'd32);
    check("busy_at_done", {63'd0, bus.mult_busy}, 64'd0);
    @(posedge CLK);
    #1;
    check("done_one_cycle", {63'd0, bus.mult_done}, 64'd0);
    check("busy_after_done", {63'd0, bus.mult_busy}, 64'd0);
  endtask

  initial begin
    int dones;
    reset           = 1'b0;
    bus.start_multE = 1'b0;
    bus.mult_signE  = 1'b0;
    bus.SrcAE       = '0;
    bus.SrcBE       = '0;
    bus.abort       = 1'b0;
    #1;
    check("rst_busy", {63'd0, bus.mult_busy}, 64'd0);
    check("rst_done", {63'd0, bus.mult_done}, 64'd0);
    check("rst_hi", {32'd0, bus.HI}, 64'd0);
    check("rst_lo", {32'd0, bus.LO}, 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    reset = 1'b1;

    // Directed products
    run_mult(32'd3, 32'd5, 1'b0, 1'b0);
    check("lo_3x5_const", {32'd0, bus.LO}, 64'd15);
    run_mult(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("hi_ffff_const", {32'd0, bus.HI}, 64'hFFFF_FFFE);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    check("hi_8000_const", {32'd0, bus.HI}, 64'h4000_0000);

    // Abort mid-operation keeps the previous result
    run_mult(32'd7, 32'd7, 1'b0, 1'b0);
    start_op(32'd2, 32'd2, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    bus.abort = 1'b1;
    @(posedge CLK);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", {63'd0, bus.mult_busy}, 64'd0);
    check("abort_done", {63'd0, bus.mult_done}, 64'd0);
    check("abort_hi", {32'd0, bus.HI}, 64'd0);
    check("abort_lo", {32'd0, bus.LO}, 64'd49);
    dones = 0;
    repeat (35) begin
      @(posedge CLK);
      #1;
      if (bus.mult_done === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // Start while busy is ignored
    run_mult(32'd1234, 32'd5678, 1'b0, 1'b1);
    run_mult(32'hFFFF_FFF0, 32'd77, 1'b1, 1'b1);

    // Abort together with start in IDLE: abort wins
    @(posedge CLK);
    #1;
    bus.start_multE = 1'b1;
    bus.abort       = 1'b1;
    bus.SrcAE       = 32'd11;
    bus.SrcBE       = 32'd13;
    @(posedge CLK);
    #1;
    bus.start_multE = 1'b0;
    bus.abort       = 1'b0;
    check("abort_start_busy", {63'd0, bus.mult_busy}, 64'd0);
    check("abort_start_done", {63'd0, bus.mult_done}, 64'd0);

    // Asynchronous reset mid-operation
    start_op(32'h1234, 32'h5678, 1'b0);
    repeat (10) @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, bus.mult_busy}, 64'd0);
    check("async_rst_done", {63'd0, bus.mult_done}, 64'd0);
    check("async_rst_hi", {32'd0, bus.HI}, 64'd0);
    check("async_rst_lo", {32'd0, bus.LO}, 64'd0);
    @(posedge CLK);
    #1;
    check("rst_held_busy", {63'd0, bus.mult_busy}, 64'd0);
    reset = 1'b1;
    run_mult(32'd6, 32'd7, 1'b0, 1'b0);
    check("lo_6x7_const", {32'd0, bus.LO}, 64'd42);

    // Randomized operands and signedness
    for (int i = 0; i < 24; i++) begin
      run_mult(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
